// File: rtl/iter_divider_hs.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : iter_divider_hs                                              |
// | Brief    : Multi-cycle restoring divider with valid/ready handshakes,   |
// |            flush, RISC-V special cases and word mode. Optional early-out|
// |            via define ITER_DIVIDER_EARLY_OUT_EN.                         |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
module iter_divider_hs #(
   parameter int WIDTH  = 64,
   parameter int WORD_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             op_signed,
   input  logic             op_word,
   input  logic [WIDTH-1:0] numerator,
   input  logic [WIDTH-1:0] denominator,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_calc = 2'd1;
   localparam logic [1:0] c_done = 2'd2;

   localparam logic [WIDTH-1:0] c_word_mask  = {WIDTH{1'b1}} >> (WIDTH - WORD_W);
   localparam logic [WIDTH-1:0] c_word_min   = c_word_mask ^ (c_word_mask >> 1);
   localparam logic [WIDTH-1:0] c_full_min   = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CW-1:0]    c_full_last  = CW'(WIDTH - 1);
   localparam logic [CW-1:0]    c_word_last  = CW'(WORD_W - 1);
   localparam logic [CW-1:0]    c_word_shift = CW'(WIDTH - WORD_W);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nx;
   logic [CW-1:0]    r_counter;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_den;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_remd;
   logic             r_qneg;
   logic             r_rneg;
   logic             r_word;

   function automatic logic [WIDTH-1:0] f_sext(input logic [WIDTH-1:0] v);
      return v[WORD_W-1] ? (v | ~c_word_mask) : (v & c_word_mask);
   endfunction

   logic [WIDTH-1:0] w_mask;
   logic [WIDTH-1:0] w_num_n;
   logic [WIDTH-1:0] w_den_n;
   logic [WIDTH-1:0] w_num_mag;
   logic [WIDTH-1:0] w_den_mag;
   logic [WIDTH-1:0] w_align;
   logic [WIDTH-1:0] w_dvd_init;
   logic [WIDTH-1:0] w_num_ext;
   logic [WIDTH-1:0] w_spec_q;
   logic [WIDTH-1:0] w_spec_r;
   logic             w_num_neg;
   logic             w_den_neg;
   logic             w_div_zero;
   logic             w_ovf;
   logic [CW-1:0]    w_shamt;
   logic [CW-1:0]    w_last;
   logic [CW-1:0]    w_start;

   assign w_mask     = op_word ? c_word_mask : {WIDTH{1'b1}};
   assign w_num_n    = numerator & w_mask;
   assign w_den_n    = denominator & w_mask;
   assign w_num_neg  = op_signed & (op_word ? numerator[WORD_W-1] : numerator[WIDTH-1]);
   assign w_den_neg  = op_signed & (op_word ? denominator[WORD_W-1] : denominator[WIDTH-1]);
   assign w_num_mag  = (w_num_neg ? -numerator : numerator) & w_mask;
   assign w_den_mag  = (w_den_neg ? -denominator : denominator) & w_mask;
   assign w_div_zero = (w_den_n == '0);
   assign w_ovf      = op_signed & (w_num_n == (op_word ? c_word_min : c_full_min))
                       & (w_den_n == w_mask);
   assign w_num_ext  = op_word ? f_sext(numerator) : numerator;
   assign w_spec_q   = w_div_zero ? {WIDTH{1'b1}} : w_num_ext;
   assign w_spec_r   = w_div_zero ? w_num_ext : '0;

   // Left-align the N-bit magnitude so the next dividend bit is always the MSB.
   assign w_shamt = op_word ? c_word_shift : '0;
   assign w_last  = op_word ? c_word_last : c_full_last;
   assign w_align = w_num_mag << w_shamt;

`ifdef ITER_DIVIDER_EARLY_OUT_EN
   function automatic logic [CW-1:0] f_lzc(input logic [WIDTH-1:0] v);
      logic [CW-1:0] n;
      logic          found;
      n     = '0;
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      n = n + 1'b1;
         end
      end
      return n;
   endfunction

   logic [CW-1:0] w_lz;

   // A zero dividend still runs one CALC cycle.
   assign w_lz       = (w_align == '0) ? w_last : f_lzc(w_align);
   assign w_start    = w_last - w_lz;
   assign w_dvd_init = w_align << w_lz;
`else
   assign w_start    = w_last;
   assign w_dvd_init = w_align;
`endif

   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;
   logic             w_qbit;
   logic [WIDTH-1:0] w_rem_nx;
   logic [WIDTH-1:0] w_dvd_nx;
   logic [WIDTH-1:0] w_q_fix;
   logic [WIDTH-1:0] w_r_fix;
   logic [WIDTH-1:0] w_q_out;
   logic [WIDTH-1:0] w_r_out;

   assign w_shift  = {r_rem, r_dvd[WIDTH-1]};
   assign w_diff   = w_shift - {1'b0, r_den};
   assign w_qbit   = ~w_diff[WIDTH];
   assign w_rem_nx = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
   assign w_dvd_nx = {r_dvd[WIDTH-2:0], w_qbit};
   assign w_q_fix  = r_qneg ? -w_dvd_nx : w_dvd_nx;
   assign w_r_fix  = r_rneg ? -w_rem_nx : w_rem_nx;
   assign w_q_out  = r_word ? f_sext(w_q_fix) : w_q_fix;
   assign w_r_out  = r_word ? f_sext(w_r_fix) : w_r_fix;

   always_ff @(posedge clk) begin
      if (reset) r_state <= c_idle;
      else       r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      if (flush) begin
         w_state_nx = c_idle;
      end else begin
         case (r_state)
            c_idle:  if (req_valid) w_state_nx = (w_div_zero | w_ovf) ? c_done : c_calc;
            c_calc:  if (r_counter == '0) w_state_nx = c_done;
            c_done:  if (resp_ready) w_state_nx = c_idle;
            default: w_state_nx = c_idle;
         endcase
      end
   end

   always_comb begin
      req_ready  = (r_state == c_idle);
      resp_valid = (r_state == c_done);
      busy       = (r_state != c_idle);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_counter <= '0;
         r_dvd     <= '0;
         r_rem     <= '0;
         r_den     <= '0;
         r_quot    <= '0;
         r_remd    <= '0;
         r_qneg    <= 1'b0;
         r_rneg    <= 1'b0;
         r_word    <= 1'b0;
      end else if (flush) begin
         r_counter <= '0;
      end else begin
         case (r_state)
            c_idle: begin
               if (req_valid) begin
                  r_dvd     <= w_dvd_init;
                  r_rem     <= '0;
                  r_den     <= w_den_mag;
                  r_qneg    <= w_num_neg ^ w_den_neg;
                  r_rneg    <= w_num_neg;
                  r_word    <= op_word;
                  r_counter <= w_start;
                  if (w_div_zero | w_ovf) begin
                     r_quot <= w_spec_q;
                     r_remd <= w_spec_r;
                  end
               end
            end
            c_calc: begin
               r_dvd <= w_dvd_nx;
               r_rem <= w_rem_nx;
               if (r_counter == '0) begin
                  r_quot <= w_q_out;
                  r_remd <= w_r_out;
               end else begin
                  r_counter <= r_counter - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign quotient  = r_quot;
   assign remainder = r_remd;

endmodule
`default_nettype wire

// File: tb/tb_iter_divider_hs.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : tb_iter_divider_hs                                           |
// | Brief    : Directed vector bench for iter_divider_hs (WIDTH=64).        |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
module tb_iter_divider_hs;

   typedef struct {
      logic        sgn;
      logic        word;
      logic [63:0] num;
      logic [63:0] den;
      logic [63:0] q;
      logic [63:0] r;
      int          lat;
      int          lat_eo;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, flush, req_valid, req_ready, op_signed, op_word;
   logic        resp_valid, resp_ready, busy;
   logic [63:0] numerator, denominator, quotient, remainder;

   int n_checks = 0;
   int n_errors = 0;

   vec_t vecs[16];

   always #5 clk = ~clk;

   iter_divider_hs #(.WIDTH(64), .WORD_W(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .op_signed   (op_signed),
      .op_word     (op_word),
      .numerator   (numerator),
      .denominator (denominator),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy)
   );

   function automatic vec_t mk(input logic s, input logic w, input logic [63:0] n,
                               input logic [63:0] d, input logic [63:0] q,
                               input logic [63:0] r, input int l, input int le);
      vec_t v;
      v.sgn = s; v.word = w; v.num = n; v.den = d; v.q = q; v.r = r;
      v.lat = l; v.lat_eo = le;
      return v;
   endfunction

   function automatic int exp_lat(input vec_t v);
`ifdef ITER_DIVIDER_EARLY_OUT_EN
      return v.lat_eo;
`else
      return v.lat;
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Latency = edges from the accept edge to the first edge that sees resp_valid.
   task automatic wait_valid(input int budget, output int lat);
      int n;
      n = 0;
      while (!resp_valid && n < budget) begin
         tick();
         n++;
      end
      lat = resp_valid ? n + 1 : -1;
   endtask

   task automatic issue(input vec_t v);
      op_signed   = v.sgn;
      op_word     = v.word;
      numerator   = v.num;
      denominator = v.den;
      req_valid   = 1'b1;
      tick();
      req_valid   = 1'b0;
      numerator   = {$urandom(), $urandom()};
      denominator = {$urandom(), $urandom()};
      op_signed   = ~op_signed;
      op_word     = ~op_word;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      resp_ready = 1'b1;
      issue(v);
      wait_valid(200, lat);
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(v)));
      if (lat > 0) begin
         chk({tag, "_q"}, quotient, v.q);
         chk({tag, "_r"}, remainder, v.r);
      end
      tick();
      chk({tag, "_back_idle"}, {61'd0, resp_valid, req_ready, busy}, 64'b010);
   endtask

   initial begin
      vec_t v;
      int   lat;
      int   seen;
      logic [63:0] hq, hr;

      vecs[0]  = mk(1, 0, -64'sd7, 64'd2, -64'sd3, -64'sd1, 65, 4);
      vecs[1]  = mk(0, 1, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 33, 33);
      vecs[2]  = mk(1, 0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1, 1);
      vecs[3]  = mk(1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'h8000_0000_0000_0000, 64'd0, 1, 1);
      vecs[4]  = mk(0, 0, 64'd5, 64'd2, 64'd2, 64'd1, 65, 4);
      vecs[5]  = mk(0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 65, 8);
      vecs[6]  = mk(1, 0, 64'd7, -64'sd2, -64'sd3, 64'd1, 65, 4);
      vecs[7]  = mk(1, 1, 64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_5678_0000_0002,
                    64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33, 4);
      vecs[8]  = mk(1, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                    64'hFFFF_FFFF_8000_0000, 64'd0, 1, 1);
      vecs[9]  = mk(0, 1, 64'h1111_1111_8000_0005, 64'hFFFF_FFFF_0000_0000,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0005, 1, 1);
      vecs[10] = mk(0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 65, 65);
      vecs[11] = mk(0, 0, 64'd0, 64'd3, 64'd0, 64'd0, 65, 2);
      vecs[12] = mk(1, 0, -64'sd100, -64'sd7, 64'd14, -64'sd2, 65, 8);
      vecs[13] = mk(0, 1, 64'hABCD_0000_0000_0007, 64'd3, 64'd2, 64'd1, 33, 4);
      vecs[14] = mk(0, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'd0, 64'h8000_0000_0000_0000, 65, 65);
      vecs[15] = mk(1, 1, 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_FFFF_FFFF,
                    64'hFFFF_FFFF_8000_0001, 64'd0, 33, 32);

      reset = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
      op_signed = 1'b0; op_word = 1'b0; numerator = '0; denominator = '0;
      repeat (3) tick();
      reset = 1'b0;
      chk("reset_flags", {61'd0, resp_valid, req_ready, busy}, 64'b010);

      for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Backpressure: result held, no accept while DONE, even on the handshake edge.
      resp_ready = 1'b0;
      issue(vecs[5]);
      wait_valid(200, lat);
      chk("bp_lat", 64'(lat), 64'(exp_lat(vecs[5])));
      hq = vecs[5].q;
      hr = vecs[5].r;
      for (int k = 0; k < 10; k++) begin
         req_valid   = 1'b1;
         numerator   = {$urandom(), $urandom()};
         denominator = {$urandom(), $urandom()};
         tick();
         chk($sformatf("bp_q%0d", k), quotient, hq);
         chk($sformatf("bp_r%0d", k), remainder, hr);
         chk($sformatf("bp_flags%0d", k), {61'd0, resp_valid, req_ready, busy}, 64'b101);
      end
      resp_ready = 1'b1;
      tick();
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      chk("bp_handshake", {61'd0, resp_valid, req_ready, busy}, 64'b010);
      tick();
      chk("bp_single", {61'd0, resp_valid, req_ready, busy}, 64'b010);

      // Flush at counter=20: accept edge loads 63, 43 further edges reach 20.
      v = vecs[10];
      issue(v);
      repeat (43) tick();
      chk("fl_busy_before", {63'd0, busy}, 64'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_after", {61'd0, resp_valid, req_ready, busy}, 64'b010);
      seen = 0;
      repeat (80) begin
         tick();
         if (resp_valid) seen++;
      end
      chk("fl_no_resp", 64'(seen), 64'd0);
      run_vec(vecs[5], "fl_next");

      // Flush in DONE drops the result even with resp_ready high.
      resp_ready = 1'b0;
      issue(vecs[4]);
      wait_valid(200, lat);
      chk("fd_valid", {63'd0, resp_valid}, 64'd1);
      flush = 1'b1;
      resp_ready = 1'b1;
      tick();
      flush = 1'b0;
      resp_ready = 1'b0;
      chk("fd_dropped", {61'd0, resp_valid, req_ready, busy}, 64'b010);
      tick();
      chk("fd_stays", {61'd0, resp_valid, req_ready, busy}, 64'b010);

      // Flush beats an accept in IDLE.
      op_signed = 1'b0; op_word = 1'b0; numerator = 64'd100; denominator = 64'd7;
      req_valid = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      req_valid = 1'b0;
      chk("fa_no_accept", {61'd0, resp_valid, req_ready, busy}, 64'b010);

      // Reset mid-calculation, with flush also high, returns to IDLE.
      issue(vecs[10]);
      repeat (3) tick();
      reset = 1'b1;
      flush = 1'b1;
      tick();
      reset = 1'b0;
      flush = 1'b0;
      chk("rst_mid", {61'd0, resp_valid, req_ready, busy}, 64'b010);
      run_vec(vecs[0], "rst_next");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
